// File: rtl/painterengine_gpu_pkg.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_pkg
// Shared definitions for the GPU burst writer: FSM state encoding, AXI4
// burst/size/response codes, the 4 KB page constant and a helper that gives
// the number of 32-bit beats left before the next page boundary.
// -----------------------------------------------------------------------------
package painterengine_gpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_RESP = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_WORDS = PAGE_BYTES / 4;

  // Beats (1..1024) from a word offset inside a page up to the next page start.
  function automatic logic [10:0] beats_to_page(input logic [9:0] word_offset);
    return 11'(PAGE_WORDS) - {1'b0, word_offset};
  endfunction

endpackage

// File: rtl/painterengine_gpu_burst_writer_if.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_burst_writer_if
// AXI4 write-channel bundle (AW, W, B) used between the burst writer and a
// memory slave.
//   master modport : drives AW/W payload + valids and bready
//   slave  modport : drives awready, wready, bresp, bvalid
// -----------------------------------------------------------------------------
interface painterengine_gpu_burst_writer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    output bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    input  bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/painterengine_gpu_burst_calc.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_burst_calc
// Combinational burst sizing: beats = min(remaining, max, beats to 4 KB page).
//   i_address   : word offset of the current address inside its 4 KB page
//   i_remaining : beats still to be written (1..256)
//   i_max       : largest burst allowed (1..256)
//   o_beats     : beats for the next burst
// -----------------------------------------------------------------------------
module painterengine_gpu_burst_calc
  import painterengine_gpu_pkg::*;
(
  input  logic [9:0] i_address,
  input  logic [8:0] i_remaining,
  input  logic [8:0] i_max,
  output logic [8:0] o_beats
);

  logic [10:0] w_page_beats;
  logic [8:0]  w_page_clamped;
  logic [8:0]  w_min_rm;

  assign w_page_beats = beats_to_page(i_address);

  // Three-way minimum; page distance is clamped to 256 first so it fits 9 bits.
  always_comb begin
    w_page_clamped = 9'd256;
    w_min_rm       = i_remaining;
    o_beats        = i_remaining;
    if (w_page_beats < 11'd256) begin
      w_page_clamped = w_page_beats[8:0];
    end else begin
      w_page_clamped = 9'd256;
    end
    if (i_max < i_remaining) begin
      w_min_rm = i_max;
    end else begin
      w_min_rm = i_remaining;
    end
    if (w_page_clamped < w_min_rm) begin
      o_beats = w_page_clamped;
    end else begin
      o_beats = w_min_rm;
    end
  end

endmodule

// File: rtl/painterengine_gpu_burst_writer.sv
// -----------------------------------------------------------------------------
// painterengine_gpu_burst_writer
// Writes a job of up to 256 32-bit words from a flat cache vector to memory as
// a sequence of AXI4 INCR bursts that never cross a 4 KB page. One burst is in
// flight at a time and AW/W phases never overlap.
//   i_wire_axi_clock / i_wire_resetn : clock, async active-low reset
//   i_wire_cache_address             : byte start address (low 2 bits ignored)
//   i_wire_cache_length              : job length in beats (0..256)
//   i_wire_cache                     : word i at bits [DATA_W*i +: DATA_W]
//   i_wire_writer_enable             : job request (needs a low cycle to rearm)
//   o_wire_writer_done               : one-cycle completion pulse
//   o_wire_error                     : sticky, set by any non-OKAY bresp
//   m_axi                            : AXI4 write master channels
// -----------------------------------------------------------------------------
module painterengine_gpu_burst_writer
  import painterengine_gpu_pkg::*;
#(
  parameter int PARAM_ADDRESS_WIDTH  = 32,
  parameter int PARAM_DATA_WIDTH     = 32,
  parameter int PARAM_CACHE_MAX_SIZE = 256,
  parameter int PARAM_MAX_BURST      = 64
) (
  input  logic                                           i_wire_axi_clock,
  input  logic                                           i_wire_resetn,
  input  logic [PARAM_ADDRESS_WIDTH-1:0]                 i_wire_cache_address,
  input  logic [8:0]                                     i_wire_cache_length,
  input  logic [PARAM_DATA_WIDTH*PARAM_CACHE_MAX_SIZE-1:0] i_wire_cache,
  input  logic                                           i_wire_writer_enable,
  output logic                                           o_wire_writer_done,
  output logic                                           o_wire_error,
  painterengine_gpu_burst_writer_if.master               m_axi
);

  localparam logic [8:0] MAX_BURST = 9'(PARAM_MAX_BURST);
  localparam logic [PARAM_ADDRESS_WIDTH-1:0] ALIGN_MASK =
    {{(PARAM_ADDRESS_WIDTH-2){1'b1}}, 2'b00};

  state_t                        r_state;
  logic                          r_armed;
  logic [PARAM_ADDRESS_WIDTH-1:0] r_addr;
  logic [8:0]                    r_remaining;
  logic [8:0]                    r_word_cnt;
  logic [8:0]                    r_beat_cnt;
  logic [8:0]                    r_burst_len;
  logic [PARAM_ADDRESS_WIDTH-1:0] r_awaddr;
  logic [7:0]                    r_awlen;
  logic                          r_awvalid;
  logic [PARAM_DATA_WIDTH-1:0]   r_wdata;
  logic                          r_wlast;
  logic                          r_wvalid;
  logic                          r_bready;
  logic                          r_done;
  logic                          r_error;

  logic [8:0]                    w_beats;
  logic [8:0]                    w_next_word;
  logic [PARAM_DATA_WIDTH-1:0]   w_words [0:511];

  // The cache is viewed as a 512-entry word array so the full 9-bit counter
  // indexes it directly; entries past the cache size read as zero.
  for (genvar gi = 0; gi < 512; gi++) begin : g_words
    if (gi < PARAM_CACHE_MAX_SIZE) begin : g_live
      assign w_words[gi] = i_wire_cache[gi*PARAM_DATA_WIDTH +: PARAM_DATA_WIDTH];
    end else begin : g_pad
      assign w_words[gi] = '0;
    end
  end

  assign w_next_word = r_word_cnt + 9'd1;

  painterengine_gpu_burst_calc u_burst_calc (
    .i_address   (r_addr[11:2]),
    .i_remaining (r_remaining),
    .i_max       (MAX_BURST),
    .o_beats     (w_beats)
  );

  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = r_awlen;
  assign m_axi.awsize  = AXI_SIZE_4B;
  assign m_axi.awburst = AXI_BURST_INCR;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = {(PARAM_DATA_WIDTH/8){1'b1}};
  assign m_axi.wlast   = r_wlast;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;
  assign o_wire_writer_done = r_done;
  assign o_wire_error       = r_error;

  // Job sequencer: IDLE -> ADDR -> DATA -> RESP -> (ADDR | DONE) -> IDLE.
  always_ff @(posedge i_wire_axi_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      r_state     <= ST_IDLE;
      r_armed     <= 1'b1;
      r_addr      <= '0;
      r_remaining <= 9'd0;
      r_word_cnt  <= 9'd0;
      r_beat_cnt  <= 9'd0;
      r_burst_len <= 9'd0;
      r_awaddr    <= '0;
      r_awlen     <= 8'd0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wlast     <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_armed && i_wire_writer_enable) begin
            r_addr      <= i_wire_cache_address & ALIGN_MASK;
            r_remaining <= i_wire_cache_length;
            r_word_cnt  <= 9'd0;
            if (i_wire_cache_length == 9'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ADDR;
            end
          end else if (!i_wire_writer_enable) begin
            r_armed <= 1'b1;
          end else begin
            r_armed <= r_armed;
          end
        end

        // First cycle loads the AW payload; it then stays frozen until awready.
        ST_ADDR: begin
          if (!r_awvalid) begin
            r_awvalid   <= 1'b1;
            r_awaddr    <= r_addr;
            r_awlen     <= 8'(w_beats - 9'd1);
            r_burst_len <= w_beats;
          end else if (m_axi.awready) begin
            r_awvalid  <= 1'b0;
            r_beat_cnt <= 9'd0;
            r_wvalid   <= 1'b1;
            r_wdata    <= w_words[r_word_cnt];
            r_wlast    <= (r_burst_len == 9'd1);
            r_state    <= ST_DATA;
          end else begin
            r_awvalid <= 1'b1;
          end
        end

        ST_DATA: begin
          if (r_wvalid && m_axi.wready) begin
            r_word_cnt <= w_next_word;
            r_beat_cnt <= r_beat_cnt + 9'd1;
            if (r_wlast) begin
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_bready <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              r_wdata <= w_words[w_next_word];
              // Beat just accepted is index r_beat_cnt; the next one is last
              // when it is index burst_len-1.
              r_wlast <= ((r_beat_cnt + 9'd2) == r_burst_len);
            end
          end else begin
            r_wvalid <= r_wvalid;
          end
        end

        ST_RESP: begin
          if (m_axi.bvalid) begin
            r_bready    <= 1'b0;
            r_addr      <= r_addr + PARAM_ADDRESS_WIDTH'({r_burst_len, 2'b00});
            r_remaining <= r_remaining - r_burst_len;
            if (m_axi.bresp != AXI_RESP_OKAY) begin
              r_error <= 1'b1;
            end else begin
              r_error <= r_error;
            end
            if (r_remaining == r_burst_len) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_ADDR;
            end
          end else begin
            r_bready <= 1'b1;
          end
        end

        ST_DONE: begin
          r_state <= ST_IDLE;
          r_armed <= 1'b0;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_painterengine_gpu_burst_writer.sv
// -----------------------------------------------------------------------------
// tb_painterengine_gpu_burst_writer
// Scoreboard bench: each job is expanded by a plain-arithmetic reference model
// into expected AW and W entries; a negedge monitor pops and compares every
// handshake. A randomized slave drives the ready/response side.
// -----------------------------------------------------------------------------
module tb_painterengine_gpu_burst_writer;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } w_t;

  logic          clk;
  logic          rst_n;
  logic [31:0]   job_addr;
  logic [8:0]    job_len;
  logic [8191:0] cache;
  logic          en;
  logic          done;
  logic          error;

  painterengine_gpu_burst_writer_if #(.ADDR_W(32), .DATA_W(32)) axi ();

  painterengine_gpu_burst_writer dut (
    .i_wire_axi_clock     (clk),
    .i_wire_resetn        (rst_n),
    .i_wire_cache_address (job_addr),
    .i_wire_cache_length  (job_len),
    .i_wire_cache         (cache),
    .i_wire_writer_enable (en),
    .o_wire_writer_done   (done),
    .o_wire_error         (error),
    .m_axi                (axi)
  );

  aw_t exp_aw[$];
  w_t  exp_w[$];
  int  n_cmp = 0;
  int  n_fail = 0;
  bit  exp_err = 1'b0;

  int  aw_hs_cnt = 0;
  int  w_hs_cnt = 0;
  int  wlast_hs_cnt = 0;
  int  b_hs_cnt = 0;
  int  done_seen = 0;
  int  b_issued = 0;
  bit  bp_en = 1'b0;
  int  err_abs = -1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: split a job into page-safe bursts of at most 64 beats.
  task automatic model_job(input logic [31:0] a, input int l, input int err_rel, output int nb);
    logic [31:0] cur;
    int rem;
    int word;
    int page;
    int n;
    cur  = a & 32'hFFFF_FFFC;
    rem  = l;
    word = 0;
    nb   = 0;
    while (rem > 0) begin
      page = (4096 - int'(cur % 32'd4096)) / 4;
      n = rem;
      if (n > 64) n = 64;
      if (page < n) n = page;
      exp_aw.push_back('{cur, 8'(n - 1)});
      for (int k = 0; k < n; k++) begin
        exp_w.push_back('{cache[(word + k) * 32 +: 32], (k == n - 1)});
      end
      if (nb == err_rel) exp_err = 1'b1;
      cur  = cur + 32'(4 * n);
      rem  = rem - n;
      word = word + n;
      nb++;
    end
  endtask

  // Slave: randomized readies, one B response per completed W burst.
  initial begin
    int seen_wlast;
    int seen_b;
    bit b_pending;
    seen_wlast = 0;
    seen_b = 0;
    b_pending = 1'b0;
    axi.awready = 1'b0;
    axi.wready  = 1'b0;
    axi.bvalid  = 1'b0;
    axi.bresp   = 2'b00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.bvalid  = 1'b0;
        b_pending   = 1'b0;
        seen_wlast  = wlast_hs_cnt;
        seen_b      = b_hs_cnt;
      end else begin
        if (b_hs_cnt != seen_b) begin
          axi.bvalid = 1'b0;
          seen_b = b_hs_cnt;
        end
        if (wlast_hs_cnt != seen_wlast) begin
          b_pending = 1'b1;
          seen_wlast = wlast_hs_cnt;
        end
        if (b_pending && !axi.bvalid && (!bp_en || ($urandom_range(0, 1) == 1))) begin
          axi.bvalid = 1'b1;
          axi.bresp  = (b_issued == err_abs) ? 2'b10 : 2'b00;
          b_issued++;
          b_pending = 1'b0;
        end
        axi.awready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        axi.wready  = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: handshakes seen at negedge complete on the following posedge.
  initial begin
    aw_t ea;
    w_t  ew;
    bit  prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (axi.awvalid && axi.awready) begin
          check("aw_w_overlap", 64'(axi.wvalid), 64'd0);
          check("aw_outstanding", 64'(aw_hs_cnt - b_hs_cnt), 64'd0);
          if (exp_aw.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL aw_unexpected: got awaddr %0h awlen %0d, expected none",
                     axi.awaddr, axi.awlen);
          end else begin
            ea = exp_aw.pop_front();
            check("awaddr", 64'(axi.awaddr), 64'(ea.addr));
            check("awlen", 64'(axi.awlen), 64'(ea.len));
            check("awsize_awburst", 64'({axi.awsize, axi.awburst}), 64'({3'b010, 2'b01}));
          end
          aw_hs_cnt++;
        end
        if (axi.wvalid && axi.wready) begin
          if (exp_w.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL w_unexpected: got wdata %0h, expected none", axi.wdata);
          end else begin
            ew = exp_w.pop_front();
            check("wdata", 64'(axi.wdata), 64'(ew.data));
            check("wlast", 64'(axi.wlast), 64'(ew.last));
            check("wstrb", 64'(axi.wstrb), 64'h0F);
          end
          w_hs_cnt++;
          if (axi.wlast) wlast_hs_cnt++;
        end
        if (axi.bvalid && axi.bready) b_hs_cnt++;
        if (done) begin
          check("done_width", 64'(prev_done), 64'd0);
          done_seen++;
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
        b_hs_cnt = aw_hs_cnt;
      end
    end
  end

  task automatic randomize_cache();
    for (int i = 0; i < 256; i++) cache[i*32 +: 32] = $urandom;
  endtask

  task automatic run_job(input logic [31:0] a, input int l, input bit bp,
                         input int err_rel, input bit hold);
    int nb;
    int start_done;
    int start_b;
    int limit;
    int c;
    randomize_cache();
    model_job(a, l, err_rel, nb);
    bp_en = bp;
    err_abs = (err_rel < 0) ? -1 : b_issued + err_rel;
    start_done = done_seen;
    start_b = b_hs_cnt;
    @(posedge clk);
    #1;
    job_addr = a;
    job_len  = 9'(l);
    en = 1'b1;
    limit = (l == 0) ? 2 : 20000;
    c = 0;
    while (c < limit && done_seen == start_done) begin
      @(posedge clk);
      c++;
    end
    #1;
    check("done_count", 64'(done_seen - start_done), 64'd1);
    check("burst_count", 64'(b_hs_cnt - start_b), 64'(nb));
    if (hold) begin
      repeat (5) @(posedge clk);
      #1;
      check("no_restart_while_enable_high", 64'(done_seen - start_done), 64'd1);
    end
    check("aw_queue_drained", 64'(exp_aw.size()), 64'd0);
    check("w_queue_drained", 64'(exp_w.size()), 64'd0);
    check("error_flag", 64'(error), 64'(exp_err));
    en = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic reset_mid_burst();
    int nb;
    int start_w;
    int c;
    randomize_cache();
    model_job(32'h0000_2000, 64, -1, nb);
    bp_en = 1'b0;
    err_abs = -1;
    start_w = w_hs_cnt;
    @(posedge clk);
    #1;
    job_addr = 32'h0000_2000;
    job_len  = 9'd64;
    en = 1'b1;
    c = 0;
    while (c < 2000 && (w_hs_cnt - start_w) < 9) begin
      @(posedge clk);
      c++;
    end
    check("reached_beat_10", 64'(w_hs_cnt - start_w >= 9), 64'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_awvalid", 64'(axi.awvalid), 64'd0);
    check("rst_wvalid", 64'(axi.wvalid), 64'd0);
    check("rst_wlast", 64'(axi.wlast), 64'd0);
    check("rst_bready", 64'(axi.bready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    exp_aw.delete();
    exp_w.delete();
    exp_err = 1'b0;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    job_addr = 32'd0;
    job_len = 9'd0;
    cache = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_awvalid", 64'(axi.awvalid), 64'd0);
    check("reset_wvalid", 64'(axi.wvalid), 64'd0);
    check("reset_wlast", 64'(axi.wlast), 64'd0);
    check("reset_bready", 64'(axi.bready), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_error", 64'(error), 64'd0);
    check("reset_awaddr", 64'(axi.awaddr), 64'd0);
    check("reset_awlen", 64'(axi.awlen), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_job(32'h0000_1000, 64, 1'b0, -1, 1'b0);
    run_job(32'h0000_1F80, 64, 1'b0, -1, 1'b0);
    run_job(32'h0000_0000, 256, 1'b0, -1, 1'b0);
    run_job(32'h0000_1F00, 200, 1'b1, 1, 1'b0);
    run_job(32'hFFFF_FF00, 128, 1'b1, -1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      run_job($urandom & 32'hFFFF_FFFC, $urandom_range(1, 256), 1'b1, -1, 1'b0);
    end
    run_job(32'h0000_4000, 0, 1'b0, -1, 1'b1);
    run_job(32'h0000_5000, 16, 1'b0, -1, 1'b1);

    reset_mid_burst();
    check("error_cleared_by_reset", 64'(error), 64'd0);
    run_job(32'h0000_3000, 100, 1'b1, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
